// File: rtl/gba_audio_sampler.sv
// GBA PWM audio to 16-bit stereo PCM: per-window duty measurement, gain with
// saturation, one-pole low-pass, and a single-entry valid/ready output stage.
module gba_audio_sampler #(
  parameter int unsigned SAMPLE_DIV = 1547,
  parameter int unsigned GAIN_SHIFT = 4,
  parameter int unsigned FILT_SHIFT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        audioLIn,
  input  logic        audioRIn,
  input  logic        sampleReady,
  output logic        sampleValid,
  output logic [15:0] sampleL,
  output logic [15:0] sampleR,
  output logic        overrun
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned SCL_W = CNT_W + 2 + GAIN_SHIFT;
  localparam int unsigned Y_W   = 18;
  localparam int unsigned F_W   = Y_W + 2;

  localparam logic signed [SCL_W-1:0] SCL_MAX = SCL_W'(32767);
  localparam logic signed [SCL_W-1:0] SCL_MIN = SCL_W'(-32768);
  localparam logic signed [F_W-1:0]   F_MAX   = F_W'(32767);
  localparam logic signed [F_W-1:0]   F_MIN   = F_W'(-32768);

  // Centre the duty count around zero, apply gain, clamp to 16-bit PCM.
  function automatic logic signed [15:0] scale(input logic [CNT_W-1:0] cnt);
    logic signed [SCL_W-1:0] raw;
    logic signed [SCL_W-1:0] shifted;
    raw     = $signed(SCL_W'({cnt, 1'b0})) - $signed(SCL_W'(SAMPLE_DIV));
    shifted = raw <<< GAIN_SHIFT;
    if (shifted > SCL_MAX)      return 16'sh7FFF;
    else if (shifted < SCL_MIN) return 16'sh8000;
    else                        return 16'(shifted);
  endfunction

  // One-pole low-pass step, saturated to the 16-bit range.
  function automatic logic signed [Y_W-1:0] filt(input logic signed [Y_W-1:0] y,
                                                  input logic signed [15:0]    x);
    logic signed [F_W-1:0] diff;
    logic signed [F_W-1:0] sum;
    diff = F_W'(x) - F_W'(y);
    sum  = F_W'(y) + (diff >>> FILT_SHIFT);
    if (sum > F_MAX)      return Y_W'(F_MAX);
    else if (sum < F_MIN) return Y_W'(F_MIN);
    else                  return Y_W'(sum);
  endfunction

  logic [1:0]              sync_l_q, sync_l_d, sync_r_q, sync_r_d;
  logic [CNT_W-1:0]        win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0]        high_l_q, high_l_d, high_r_q, high_r_d;
  logic [CNT_W-1:0]        cnt_l, cnt_r;
  logic                    win_end;
  logic                    v1_q, v1_d, v2_q, v2_d;
  logic signed [15:0]      scl_l_q, scl_l_d, scl_r_q, scl_r_d;
  logic signed [Y_W-1:0]   y_l_q, y_l_d, y_r_q, y_r_d;
  logic                    valid_q, valid_d, overrun_q, overrun_d;
  logic [15:0]             out_l_q, out_l_d, out_r_q, out_r_d;

  always_comb begin
    sync_l_d  = {sync_l_q[0], audioLIn};
    sync_r_d  = {sync_r_q[0], audioRIn};
    win_end   = (win_cnt_q == CNT_W'(SAMPLE_DIV - 1));
    // The window-end cycle's own input is folded into the captured count.
    cnt_l     = high_l_q + CNT_W'(sync_l_q[1]);
    cnt_r     = high_r_q + CNT_W'(sync_r_q[1]);
    win_cnt_d = win_end ? '0 : win_cnt_q + CNT_W'(1);
    high_l_d  = win_end ? '0 : cnt_l;
    high_r_d  = win_end ? '0 : cnt_r;

    v1_d    = win_end;
    scl_l_d = win_end ? scale(cnt_l) : scl_l_q;
    scl_r_d = win_end ? scale(cnt_r) : scl_r_q;

    v2_d  = v1_q;
    y_l_d = v1_q ? filt(y_l_q, scl_l_q) : y_l_q;
    y_r_d = v1_q ? filt(y_r_q, scl_r_q) : y_r_q;

    // Output stage: a load always wins; an unconsumed sample being replaced flags overrun.
    valid_d   = valid_q & ~sampleReady;
    out_l_d   = out_l_q;
    out_r_d   = out_r_q;
    overrun_d = 1'b0;
    if (v2_q) begin
      valid_d   = 1'b1;
      out_l_d   = y_l_q[15:0];
      out_r_d   = y_r_q[15:0];
      overrun_d = valid_q & ~sampleReady;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_l_q  <= '0;
      sync_r_q  <= '0;
      win_cnt_q <= '0;
      high_l_q  <= '0;
      high_r_q  <= '0;
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      scl_l_q   <= '0;
      scl_r_q   <= '0;
      y_l_q     <= '0;
      y_r_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      out_l_q   <= '0;
      out_r_q   <= '0;
    end else begin
      sync_l_q  <= sync_l_d;
      sync_r_q  <= sync_r_d;
      win_cnt_q <= win_cnt_d;
      high_l_q  <= high_l_d;
      high_r_q  <= high_r_d;
      v1_q      <= v1_d;
      v2_q      <= v2_d;
      scl_l_q   <= scl_l_d;
      scl_r_q   <= scl_r_d;
      y_l_q     <= y_l_d;
      y_r_q     <= y_r_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      out_l_q   <= out_l_d;
      out_r_q   <= out_r_d;
    end
  end

  assign sampleValid = valid_q;
  assign sampleL     = out_l_q;
  assign sampleR     = out_r_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_gba_audio_sampler.sv
// Bench for gba_audio_sampler: three parameterisations share one stimulus stream
// and are checked against a window-sum reference model plus fixed expected values.
module tb_gba_audio_sampler;

  localparam int D = 16;

  logic        clk = 1'b0;
  logic        rst, audio_l, audio_r, ready;
  logic [2:0]  vo, oo;
  logic [15:0] lo [3];
  logic [15:0] ro [3];

  int n_pass = 0;
  int n_chk  = 0;

  // Reference model state: input history since reset and per-DUT expected outputs.
  bit ql[$];
  bit qr[$];
  int y_l[3], y_r[3], m_l[3], m_r[3];
  bit m_v[3], m_o[3];

  always #5 clk = ~clk;

  gba_audio_sampler #(.SAMPLE_DIV(16), .GAIN_SHIFT(4), .FILT_SHIFT(0)) u_d0 (
    .clk(clk), .rst(rst), .audioLIn(audio_l), .audioRIn(audio_r), .sampleReady(ready),
    .sampleValid(vo[0]), .sampleL(lo[0]), .sampleR(ro[0]), .overrun(oo[0]));
  gba_audio_sampler #(.SAMPLE_DIV(16), .GAIN_SHIFT(12), .FILT_SHIFT(0)) u_d1 (
    .clk(clk), .rst(rst), .audioLIn(audio_l), .audioRIn(audio_r), .sampleReady(ready),
    .sampleValid(vo[1]), .sampleL(lo[1]), .sampleR(ro[1]), .overrun(oo[1]));
  gba_audio_sampler #(.SAMPLE_DIV(16), .GAIN_SHIFT(4), .FILT_SHIFT(1)) u_d2 (
    .clk(clk), .rst(rst), .audioLIn(audio_l), .audioRIn(audio_r), .sampleReady(ready),
    .sampleValid(vo[2]), .sampleL(lo[2]), .sampleR(ro[2]), .overrun(oo[2]));

  function automatic int gain_of(int i);
    return (i == 1) ? 12 : 4;
  endfunction

  function automatic int filt_of(int i);
    return (i == 2) ? 1 : 0;
  endfunction

  function automatic int sat16(longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  // Sample value of a window with c high cycles, after gain and saturation.
  function automatic int pcm(int c, int g);
    longint raw;
    raw = longint'(2 * c - D) * (longint'(1) << g);
    return sat16(raw);
  endfunction

  function automatic int lp(int y, int x, int f);
    return sat16(longint'(y + ((x - y) >>> f)));
  endfunction

  // Drive one cycle, advance the model across the clock edge, land on the falling edge.
  task automatic tick(input bit l, input bit r, input bit rdy, input bit rs);
    int p, w, cl, cr;
    bit load;
    audio_l = l;
    audio_r = r;
    ready   = rdy;
    rst     = rs;
    @(posedge clk);
    if (rs) begin
      ql.delete();
      qr.delete();
      for (int i = 0; i < 3; i++) begin
        y_l[i] = 0; y_r[i] = 0; m_l[i] = 0; m_r[i] = 0; m_v[i] = 0; m_o[i] = 0;
      end
    end else begin
      p = ql.size();
      ql.push_back(l);
      qr.push_back(r);
      // A window ending at cycle T shows up at T+3; its synchronised inputs are raw inputs 2 cycles older.
      load = (p >= 2) && (((p - 2) % D) == D - 1);
      cl = 0;
      cr = 0;
      if (load) begin
        w = (p - 2) / D;
        for (int k = w * D - 2; k <= w * D + D - 3; k++) begin
          if (k >= 0) begin
            cl += int'(ql[k]);
            cr += int'(qr[k]);
          end
        end
      end
      for (int i = 0; i < 3; i++) begin
        if (load) begin
          m_o[i] = m_v[i] && !rdy;
          y_l[i] = lp(y_l[i], pcm(cl, gain_of(i)), filt_of(i));
          y_r[i] = lp(y_r[i], pcm(cr, gain_of(i)), filt_of(i));
          m_v[i] = 1'b1;
          m_l[i] = y_l[i];
          m_r[i] = y_r[i];
        end else begin
          m_o[i] = 1'b0;
          if (rdy) m_v[i] = 1'b0;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if ({vo[i], oo[i], lo[i], ro[i]} !== 34'd0)
        $display("FAIL reset dut%0d: valid=%b ovr=%b L=%h R=%h, want all zero", i, vo[i], oo[i], lo[i], ro[i]);
      else n_pass++;
    end
  endtask

  task automatic test_const_high();
    int w = 0;
    tick(0, 0, 1, 1);
    for (int c = 0; c < 6 * D + 4; c++) begin
      tick(1, 1, 1, 0);
      if (vo[0]) begin
        n_chk++;
        if (ql.size() !== w * D + 18)
          $display("FAIL const_high_timing: valid at cycle %0d, want %0d", ql.size(), w * D + 18);
        else n_pass++;
        if (w >= 1) begin
          n_chk++;
          if ({lo[0], ro[0], lo[1], ro[1]} !== {16'd256, 16'd256, 16'h7FFF, 16'h7FFF})
            $display("FAIL const_high_data w%0d: d0 %0d/%0d d1 %0d/%0d, want 256/256 32767/32767",
                     w, $signed(lo[0]), $signed(ro[0]), $signed(lo[1]), $signed(ro[1]));
          else n_pass++;
        end
        w++;
      end
    end
    n_chk++;
    if (w !== 6) $display("FAIL const_high_count: %0d samples, want 6", w);
    else n_pass++;
  endtask

  task automatic test_square_wave();
    int w = 0;
    tick(0, 0, 1, 1);
    for (int c = 0; c < 6 * D + 4; c++) begin
      tick((ql.size() % 4) < 2, 0, 1, 0);
      if (vo[0]) begin
        if (w >= 1) begin
          n_chk++;
          if ({lo[0], ro[0], lo[1], ro[1]} !== {16'd0, 16'hFF00, 16'd0, 16'h8000})
            $display("FAIL square w%0d: d0 %0d/%0d d1 %0d/%0d, want 0/-256 0/-32768",
                     w, $signed(lo[0]), $signed(ro[0]), $signed(lo[1]), $signed(ro[1]));
          else n_pass++;
        end
        w++;
      end
    end
    n_chk++;
    if (w !== 6) $display("FAIL square_count: %0d samples, want 6", w);
    else n_pass++;
  endtask

  task automatic test_saturation();
    int w = 0;
    tick(0, 0, 1, 1);
    for (int c = 0; c < 4 * D + 4; c++) begin
      tick(1, 0, 1, 0);
      if (vo[1]) begin
        if (w >= 1) begin
          n_chk++;
          if ({lo[1], ro[1], lo[0], ro[0]} !== {16'h7FFF, 16'h8000, 16'd256, 16'hFF00})
            $display("FAIL saturation w%0d: d1 %0d/%0d d0 %0d/%0d, want 32767/-32768 256/-256",
                     w, $signed(lo[1]), $signed(ro[1]), $signed(lo[0]), $signed(ro[0]));
          else n_pass++;
        end
        w++;
      end
    end
  endtask

  task automatic test_filter_step();
    int w = 0;
    int exp2[6] = '{0, 0, 128, 192, 224, 240};
    int exp0[6] = '{0, 0, 256, 256, 256, 256};
    int p;
    tick(0, 0, 1, 1);
    for (int c = 0; c < 6 * D + 4; c++) begin
      p = ql.size();
      tick((p >= 30) ? 1'b1 : ((p % 4) < 2), 0, 1, 0);
      if (vo[2] && w < 6) begin
        n_chk++;
        if ({lo[2], lo[0]} !== {16'(exp2[w]), 16'(exp0[w])})
          $display("FAIL filter_step w%0d: filtered L=%0d unfiltered L=%0d, want %0d and %0d",
                   w, $signed(lo[2]), $signed(lo[0]), exp2[w], exp0[w]);
        else n_pass++;
        w++;
      end
    end
  endtask

  task automatic test_overrun();
    int p;
    int n_ovr = 0;
    bit rdy;
    tick(0, 0, 1, 1);
    for (int c = 0; c < 6 * D; c++) begin
      p = ql.size();
      rdy = (p < 18) || (p == 49) || (p == 50) || (p == 66);
      tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rdy, 0);
      for (int i = 0; i < 3; i++) begin
        n_chk++;
        if ({vo[i], oo[i], lo[i], ro[i]} !== {m_v[i], m_o[i], 16'(m_l[i]), 16'(m_r[i])})
          $display("FAIL overrun_model dut%0d cyc%0d: v=%b o=%b L=%0d R=%0d, want v=%b o=%b L=%0d R=%0d",
                   i, ql.size(), vo[i], oo[i], $signed(lo[i]), $signed(ro[i]), m_v[i], m_o[i], m_l[i], m_r[i]);
        else n_pass++;
      end
      if (oo[0]) n_ovr++;
      if (ql.size() == 34) begin
        n_chk++;
        if ({vo[0], oo[0]} !== 2'b11) $display("FAIL overrun_pulse: valid=%b ovr=%b, want 1 1", vo[0], oo[0]);
        else n_pass++;
      end
      if (ql.size() == 50) begin
        n_chk++;
        if ({vo[0], oo[0]} !== 2'b10) $display("FAIL load_with_transfer: valid=%b ovr=%b, want 1 0", vo[0], oo[0]);
        else n_pass++;
      end
      if (ql.size() == 51) begin
        n_chk++;
        if (vo[0] !== 1'b0) $display("FAIL valid_drop_after_transfer: valid=%b, want 0", vo[0]);
        else n_pass++;
      end
    end
    n_chk++;
    if (n_ovr !== 1) $display("FAIL overrun_count: %0d pulses, want 1", n_ovr);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int n;
    tick(0, 0, 0, 1);
    while (ql.size() < 25) tick(1, 1, 0, 0);
    n_chk++;
    if (vo[0] !== 1'b1) $display("FAIL mid_reset_pre: valid=%b, want 1", vo[0]);
    else n_pass++;
    tick(1, 1, 0, 1);
    n_chk++;
    if ({vo, oo, lo[0], ro[0], lo[2]} !== 54'd0)
      $display("FAIL mid_reset_clear: valid=%b ovr=%b L=%h R=%h, want all zero", vo, oo, lo[0], ro[0]);
    else n_pass++;
    n = 1;
    while (!vo[0] && n < 40) begin
      tick(1, 1, 0, 0);
      n++;
    end
    n_chk++;
    if (n !== 19) $display("FAIL mid_reset_latency: valid after %0d cycles, want 19", n);
    else n_pass++;
  endtask

  task automatic test_random();
    bit rs;
    tick(0, 0, 0, 1);
    for (int c = 0; c < 400; c++) begin
      rs = ($urandom_range(0, 149) == 0);
      tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), rs);
      for (int i = 0; i < 3; i++) begin
        n_chk++;
        if ({vo[i], oo[i], lo[i], ro[i]} !== {m_v[i], m_o[i], 16'(m_l[i]), 16'(m_r[i])})
          $display("FAIL random_model dut%0d iter%0d: v=%b o=%b L=%0d R=%0d, want v=%b o=%b L=%0d R=%0d",
                   i, c, vo[i], oo[i], $signed(lo[i]), $signed(ro[i]), m_v[i], m_o[i], m_l[i], m_r[i]);
        else n_pass++;
      end
    end
  endtask

  initial begin
    rst     = 1'b1;
    audio_l = 1'b0;
    audio_r = 1'b0;
    ready   = 1'b0;
    test_reset();
    test_const_high();
    test_square_wave();
    test_saturation();
    test_filter_step();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/gba_audio_sampler.md
GBA_AUDIO_SAMPLER -- requirements
Module: gbaAudioSampler

Interface
REQ-001 Parameter SAMPLE_DIV, default 1547: clk cycles per output sample window; legal range 4..65535.
REQ-002 Parameter GAIN_SHIFT, default 4: left shift applied to the centred duty value.
REQ-003 Parameter FILT_SHIFT, default 2: one-pole low-pass coefficient 2^-FILT_SHIFT; 0 = bypass.
REQ-004 clk  input  1  pixel clock; the only clock; all logic SHALL be on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 audioLIn  input  1  left GBA PWM audio, asynchronous to clk.
REQ-007 audioRIn  input  1  right GBA PWM audio, asynchronous to clk.
REQ-008 sampleReady  input  1  consumer (HDMI audio packetiser) accepts the sample this cycle.
REQ-009 sampleValid  output  1  sampleL/sampleR hold a valid, unconsumed sample.
REQ-010 sampleL  output  16  signed two's-complement left PCM.
REQ-011 sampleR  output  16  signed two's-complement right PCM.
REQ-012 overrun  output  1  one-cycle pulse: an unconsumed sample was overwritten.

Function
REQ-013 Each audio input SHALL pass through a 2-FF synchroniser before any use.
REQ-014 Window counter winCnt SHALL count 0..SAMPLE_DIV-1 and wrap to 0; "window end" = cycle with winCnt==SAMPLE_DIV-1.
REQ-015 Per channel, highCnt SHALL count cycles with synchronised input high; the window-end cycle's input SHALL be included.
REQ-016 At window end, the final count SHALL be captured and highCnt SHALL restart from that cycle's next window (0 or 1 per next input, no lost cycle).
REQ-017 The centred value SHALL be raw = 2*highCnt - SAMPLE_DIV, signed, range [-SAMPLE_DIV, +SAMPLE_DIV].
REQ-018 The scaled value SHALL be raw << GAIN_SHIFT, saturated to [-32768, 32767]; intermediate width sufficient that no wrap occurs before saturation.
REQ-019 Filter state y (18-bit signed, reset 0): y <= y + ((x - y) >>> FILT_SHIFT), arithmetic shift, result saturated to 16-bit range; FILT_SHIFT==0 SHALL give y == x.
REQ-020 Filter state SHALL update once per window, both channels in the same cycle.
REQ-021 Pipeline: window end at cycle T; scaled value registered at T+1; filter output at T+2; sampleValid asserted with new data at T+3. Latency SHALL be exactly 3 cycles.
REQ-022 Output data SHALL be stable while sampleValid is high and no new sample is loaded.
REQ-023 Transfer occurs on any cycle with sampleValid && sampleReady; sampleValid SHALL deassert the next cycle unless a new sample loads that same cycle.
REQ-024 New sample loads while sampleValid high and sampleReady low: data SHALL be replaced, sampleValid SHALL stay high, overrun SHALL pulse high for that one cycle.
REQ-025 New sample loads in the same cycle as a transfer: new data SHALL load, sampleValid SHALL stay high, overrun SHALL stay low.
REQ-026 sampleReady while sampleValid low SHALL have no effect.

Reset
REQ-027 While rst is high: synchronisers, winCnt, highCnt, pipeline registers and filter state SHALL be 0; sampleValid=0, sampleL=sampleR=0, overrun=0.
REQ-028 rst asserted mid-window or mid-pipeline SHALL discard all in-flight samples; no sampleValid SHALL occur until 3 cycles after the first full window after rst deasserts.
REQ-029 The first window after reset includes 2 synchroniser-fill cycles reading 0; this is accepted behaviour.

Verification (SAMPLE_DIV=16, GAIN_SHIFT=4, FILT_SHIFT=0 unless stated; first window discarded)
REQ-030 Both inputs constant high -> every sample L=R=+256; sampleValid exactly 3 cycles after each window end; one sample per 16 cycles.
REQ-031 L square wave, 50% duty, period 4; R constant low -> L=0, R=-256.
REQ-032 GAIN_SHIFT=12, L high, R low -> L=+32767, R=-32768 (saturation, no wrap).
REQ-033 FILT_SHIFT=1, filter state 0, L steps to constant high -> successive L samples 128, 192, 224, 240.
REQ-034 sampleReady held low for 2 windows -> second sample overwrites first, overrun pulses once, sampleValid stays high; sampleReady pulsed on the window-end+3 cycle -> no overrun.
REQ-035 rst pulsed 1 cycle at winCnt=9 with sampleValid high -> outputs 0 next cycle; next sampleValid exactly 19 cycles after rst deasserts.
